// File: rtl/snow64_alu_vec_sequencer_pkg.sv
// Shared ALU types for Snow64, plus the vector sequencer's state,
// width constants, request/result structs and the opcode legality check.
package PkgSnow64Alu;

   localparam int WIDTH__OF_64               = 64;
   localparam int MSB_POS__OF_64             = WIDTH__OF_64 - 1;
   localparam int WIDTH__OF_256              = 256;
   localparam int MSB_POS__OF_256            = WIDTH__OF_256 - 1;
   localparam int MSB_POS__ALU_VEC_SEQ_COUNT = 1;

   typedef enum logic [3:0] {
      OpAdd      = 4'd0,
      OpSub      = 4'd1,
      OpSlt      = 4'd2,
      OpDummy0   = 4'd3,
      OpDummy1   = 4'd4,
      OpAnd      = 4'd5,
      OpOrr      = 4'd6,
      OpXor      = 4'd7,
      OpShl      = 4'd8,
      OpShr      = 4'd9,
      OpInv      = 4'd10,
      OpNot      = 4'd11,
      OpAddAgain = 4'd12,
      OpDummy2   = 4'd13,
      OpDummy3   = 4'd14,
      OpDummy4   = 4'd15
   } AluOper;

   typedef struct packed {
      logic [MSB_POS__OF_64:0] a;
      logic [MSB_POS__OF_64:0] b;
      AluOper                  oper;
      logic                    unsgn_or_sgn;
   } PortIn_Alu64;

   typedef struct packed {
      logic [MSB_POS__OF_64:0] data;
   } PortOut_Alu64;

   typedef enum logic [1:0] {
      Idle = 2'd0,
      Run  = 2'd1,
      Done = 2'd2
   } AluVecSeqState;

   typedef struct packed {
      logic [MSB_POS__OF_256:0]            a;
      logic [MSB_POS__OF_256:0]            b;
      AluOper                              oper;
      logic                                unsgn_or_sgn;
      logic [MSB_POS__ALU_VEC_SEQ_COUNT:0] count_m1;
   } PortIn_AluVecSeq;

   typedef struct packed {
      logic [MSB_POS__OF_256:0] data;
      logic                     err;
   } PortOut_AluVecSeq;

   function automatic logic is_legal_alu_oper(input AluOper op);
      logic legal;
      case (op)
         OpAdd, OpSub, OpSlt, OpAnd, OpOrr, OpXor,
         OpShl, OpShr, OpInv, OpNot, OpAddAgain: legal = 1'b1;
         default:                                legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/snow64_alu_vec_sequencer.sv
// Runs a vector ALU op one 64-bit element per cycle through a shared,
// combinational Alu64 owned by the parent; result offered via valid/ready.
module snow64_alu_vec_sequencer
   import PkgSnow64Alu::*;
#(
   parameter int unsigned NUM_ELEMS = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    out_ready_in,
   input  logic [NUM_ELEMS*64-1:0] in_a,
   input  logic [NUM_ELEMS*64-1:0] in_b,
   input  AluOper                  in_oper,
   input  logic                    in_unsgn_or_sgn,
   input  logic [1:0]              in_count_m1,
   output PortIn_Alu64             out_alu,
   input  PortOut_Alu64            in_alu,
   output logic                    out_valid,
   input  logic                    in_ready_out,
   output logic [NUM_ELEMS*64-1:0] out_data,
   output logic                    out_err
);

   localparam int unsigned VecW = NUM_ELEMS * 64;

   AluVecSeqState   r_state;
   AluVecSeqState   w_next_state;
   logic [VecW-1:0] r_a;
   logic [VecW-1:0] r_b;
   logic [VecW-1:0] r_data;
   AluOper          r_oper;
   logic            r_unsgn_or_sgn;
   logic [1:0]      r_count_m1;
   logic [1:0]      r_idx;
   logic            r_err;
   logic            w_accept;
   logic            w_legal;

   assign out_ready_in = (r_state == Idle);
   assign out_valid    = (r_state == Done);
   assign out_data     = r_data;
   assign out_err      = r_err;
   assign w_accept     = in_valid && out_ready_in;
   assign w_legal      = is_legal_alu_oper(in_oper);

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         Idle: if (w_accept) w_next_state = w_legal ? Run : Done;
         Run:  if (r_idx == r_count_m1) w_next_state = Done;
         Done: if (in_ready_out) w_next_state = Idle;
         default: w_next_state = Idle;
      endcase
   end

   // The ALU bus is only non-zero while an element is being issued.
   always_comb begin
      out_alu = '0;
      if (r_state == Run) begin
         for (int unsigned k = 0; k < NUM_ELEMS; k++) begin
            if (32'(r_idx) == k) begin
               out_alu.a = r_a[k*64 +: 64];
               out_alu.b = r_b[k*64 +: 64];
            end
         end
         out_alu.oper         = r_oper;
         out_alu.unsgn_or_sgn = r_unsgn_or_sgn;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= Idle;
         r_a            <= '0;
         r_b            <= '0;
         r_data         <= '0;
         r_oper         <= OpAdd;
         r_unsgn_or_sgn <= 1'b0;
         r_count_m1     <= '0;
         r_idx          <= '0;
         r_err          <= 1'b0;
      end else begin
         r_state <= w_next_state;
         if (w_accept) begin
            r_a            <= in_a;
            r_b            <= in_b;
            r_oper         <= in_oper;
            r_unsgn_or_sgn <= in_unsgn_or_sgn;
            r_count_m1     <= in_count_m1;
            r_idx          <= '0;
            r_data         <= '0;
            r_err          <= !w_legal;
         end else if (r_state == Run) begin
            for (int unsigned k = 0; k < NUM_ELEMS; k++) begin
               if (32'(r_idx) == k) r_data[k*64 +: 64] <= in_alu.data;
            end
            r_idx <= r_idx + 2'd1;
         end
      end
   end

endmodule

// File: tb/tb_snow64_alu_vec_sequencer.sv
// Bench for the vector sequencer: a behavioural Alu64 answers the ALU bus,
// and expected vectors are built element-wise from the operation rules.
module tb_snow64_alu_vec_sequencer;
   import PkgSnow64Alu::*;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         out_ready_in;
   logic [255:0] in_a = '0;
   logic [255:0] in_b = '0;
   AluOper       in_oper = OpAdd;
   logic         in_unsgn_or_sgn = 1'b0;
   logic [1:0]   in_count_m1 = '0;
   PortIn_Alu64  out_alu;
   PortOut_Alu64 in_alu;
   logic         out_valid;
   logic         in_ready_out = 1'b0;
   logic [255:0] out_data;
   logic         out_err;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          lat;
   int          n_seen;
   PortIn_Alu64 seen[8];

   always #5 clk = ~clk;

   snow64_alu_vec_sequencer #(.NUM_ELEMS(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .out_ready_in(out_ready_in),
      .in_a(in_a), .in_b(in_b), .in_oper(in_oper), .in_unsgn_or_sgn(in_unsgn_or_sgn),
      .in_count_m1(in_count_m1), .out_alu(out_alu), .in_alu(in_alu),
      .out_valid(out_valid), .in_ready_out(in_ready_out), .out_data(out_data),
      .out_err(out_err)
   );

   function automatic logic [63:0] ref_alu(input logic [63:0] a, input logic [63:0] b,
                                           input AluOper op, input logic sgn);
      logic [5:0] sh;
      sh = b[5:0];
      case (op)
         OpAdd, OpAddAgain: return a + b;
         OpSub: return a - b;
         OpSlt: return sgn ? {63'd0, $signed(a) < $signed(b)} : {63'd0, a < b};
         OpAnd: return a & b;
         OpOrr: return a | b;
         OpXor: return a ^ b;
         OpShl: return a << sh;
         OpShr: return sgn ? 64'($signed(a) >>> sh) : (a >> sh);
         OpInv: return ~a;
         OpNot: return {63'd0, a == 64'd0};
         default: return 64'd0;
      endcase
   endfunction

   function automatic bit tb_legal(input AluOper op);
      return !(op inside {OpDummy0, OpDummy1, OpDummy2, OpDummy3, OpDummy4});
   endfunction

   function automatic logic [255:0] exp_vec(input logic [255:0] a, input logic [255:0] b,
                                            input AluOper op, input logic sgn,
                                            input logic [1:0] cm1);
      logic [255:0] r;
      r = '0;
      if (tb_legal(op))
         for (int k = 0; k <= int'(cm1); k++)
            r[k*64 +: 64] = ref_alu(a[k*64 +: 64], b[k*64 +: 64], op, sgn);
      return r;
   endfunction

   always_comb in_alu.data = ref_alu(out_alu.a, out_alu.b, out_alu.oper, out_alu.unsgn_or_sgn);

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [255:0] rand256;
      return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   // Issues a request (unless already accepted), scrambles the inputs, then
   // records the ALU bus each cycle and the cycle count until out_valid.
   task automatic do_req(input logic [255:0] a, input logic [255:0] b, input AluOper op,
                         input logic sgn, input logic [1:0] cm1, input bit pre_accepted);
      if (!pre_accepted) begin
         in_a = a; in_b = b; in_oper = op; in_unsgn_or_sgn = sgn; in_count_m1 = cm1;
         in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      in_a = rand256(); in_b = rand256();
      in_oper = AluOper'(4'($urandom)); in_unsgn_or_sgn = 1'($urandom);
      in_count_m1 = 2'($urandom);
      n_seen = 0;
      lat = -1;
      for (int c = 1; c <= 12 && lat < 0; c++) begin
         if (out_valid) lat = c;
         else begin
            if (n_seen < 8) seen[n_seen] = out_alu;
            n_seen++;
            tick();
         end
      end
   endtask

   task automatic drain;
      in_ready_out = 1'b1;
      tick();
      in_ready_out = 1'b0;
   endtask

   task automatic test_reset;
      in_valid = 1'b1; in_count_m1 = 2'd3; in_oper = OpAdd;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_tests++;
         if (out_valid !== 1'b0 || out_alu !== '0 || out_ready_in !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_outs: valid=%b alu=%h ready=%b want 0,0,1",
                     out_valid, out_alu, out_ready_in);
         end
      end
      rst = 1'b0; in_valid = 1'b0;
      n_tests++;
      if (out_data !== '0 || out_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_data: data=%h err=%b want 0,0", out_data, out_err);
      end
      tick();
      n_tests++;
      if (out_ready_in !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_no_accept: ready=%b valid=%b want 1,0", out_ready_in, out_valid);
      end
   endtask

   task automatic test_vec_add;
      logic [255:0] a, b, want;
      logic [63:0]  ea [4];
      a = {64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'd2, 64'd1};
      b = {64'd1, 64'd30, 64'd20, 64'd10};
      want = {64'd0, 64'd33, 64'd22, 64'd11};
      ea = '{64'd1, 64'd2, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF};
      do_req(a, b, OpAdd, 1'b0, 2'd3, 1'b0);
      n_tests++;
      if (lat !== 5 || n_seen !== 4) begin
         n_fail++;
         $display("FAIL vec_add_latency: lat=%0d run=%0d want 5,4", lat, n_seen);
      end
      for (int k = 0; k < 4; k++) begin
         n_tests++;
         if (seen[k].a !== ea[k] || seen[k].oper !== OpAdd) begin
            n_fail++;
            $display("FAIL vec_add_alu_a[%0d]: got %h op %0d want %h op 0",
                     k, seen[k].a, seen[k].oper, ea[k]);
         end
      end
      n_tests++;
      if (out_data !== want || out_err !== 1'b0) begin
         n_fail++;
         $display("FAIL vec_add_data: got %h err %b want %h err 0", out_data, out_err, want);
      end
      drain();
   endtask

   task automatic test_scalar;
      logic [255:0] a, b;
      a = rand256(); b = rand256();
      a[63:0] = 64'hFFFF_FFFF_FFFF_FFFF;
      b[63:0] = 64'd0;
      do_req(a, b, OpSlt, 1'b1, 2'd0, 1'b0);
      n_tests++;
      if (lat !== 2 || n_seen !== 1) begin
         n_fail++;
         $display("FAIL scalar_latency: lat=%0d run=%0d want 2,1", lat, n_seen);
      end
      n_tests++;
      if (seen[0].oper !== OpSlt || seen[0].unsgn_or_sgn !== 1'b1 || seen[0].a !== a[63:0]) begin
         n_fail++;
         $display("FAIL scalar_alu_bus: got %h want a=%h op=2 sgn=1", seen[0], a[63:0]);
      end
      n_tests++;
      if (out_data !== 256'd1) begin
         n_fail++;
         $display("FAIL scalar_data: got %h want 1", out_data);
      end
      drain();
   endtask

   task automatic test_illegal;
      do_req(rand256(), rand256(), OpDummy2, 1'b0, 2'd3, 1'b0);
      n_tests++;
      if (lat !== 1 || n_seen !== 0) begin
         n_fail++;
         $display("FAIL illegal_latency: lat=%0d run=%0d want 1,0", lat, n_seen);
      end
      n_tests++;
      if (out_err !== 1'b1 || out_data !== '0 || out_alu !== '0) begin
         n_fail++;
         $display("FAIL illegal_outs: err=%b data=%h alu=%h want 1,0,0", out_err, out_data, out_alu);
      end
      drain();
   endtask

   task automatic test_back_to_back;
      logic [255:0] a1, b1, a2, b2, want1, want2;
      AluOper op1, op2;
      logic s1, s2;
      a1 = rand256(); b1 = rand256(); a2 = rand256(); b2 = rand256();
      op1 = OpXor; op2 = OpSub; s1 = 1'($urandom); s2 = 1'($urandom);
      want1 = exp_vec(a1, b1, op1, s1, 2'd1);
      want2 = exp_vec(a2, b2, op2, s2, 2'd2);
      do_req(a1, b1, op1, s1, 2'd1, 1'b0);
      n_tests++;
      if (lat !== 3) begin
         n_fail++;
         $display("FAIL b2b_latency1: got %0d want 3", lat);
      end
      in_a = a2; in_b = b2; in_oper = op2; in_unsgn_or_sgn = s2; in_count_m1 = 2'd2;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         n_tests++;
         if (out_valid !== 1'b1 || out_data !== want1 || out_ready_in !== 1'b0 || out_err !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_hold[%0d]: valid=%b ready=%b err=%b data=%h want 1,0,0 %h",
                     i, out_valid, out_ready_in, out_err, out_data, want1);
         end
         tick();
      end
      in_ready_out = 1'b1;
      tick();
      in_ready_out = 1'b0;
      n_tests++;
      if (out_ready_in !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_idle_after_done: ready=%b valid=%b want 1,0", out_ready_in, out_valid);
      end
      tick();
      n_tests++;
      if (out_ready_in !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_next_accept: ready=%b want 0", out_ready_in);
      end
      do_req(a2, b2, op2, s2, 2'd2, 1'b1);
      n_tests++;
      if (lat !== 4 || out_data !== want2) begin
         n_fail++;
         $display("FAIL b2b_second: lat=%0d data=%h want 4 %h", lat, out_data, want2);
      end
      drain();
   endtask

   task automatic test_reset_mid;
      in_a = rand256(); in_b = rand256(); in_oper = OpAdd; in_count_m1 = 2'd3;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_tests++;
      if (out_ready_in !== 1'b1 || out_valid !== 1'b0 || out_data !== '0 || out_alu !== '0) begin
         n_fail++;
         $display("FAIL reset_mid_outs: ready=%b valid=%b data=%h alu=%h want 1,0,0,0",
                  out_ready_in, out_valid, out_data, out_alu);
      end
      for (int i = 0; i < 6; i++) begin
         tick();
         n_tests++;
         if (out_valid !== 1'b0 || out_ready_in !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_quiet[%0d]: valid=%b ready=%b want 0,1", i, out_valid, out_ready_in);
         end
      end
   endtask

   task automatic test_random;
      logic [255:0] a, b, want;
      AluOper op;
      logic sg;
      logic [1:0] cm1;
      int want_lat;
      for (int it = 0; it < 30; it++) begin
         a = rand256(); b = rand256();
         op = AluOper'(4'($urandom)); sg = 1'($urandom); cm1 = 2'($urandom);
         want = exp_vec(a, b, op, sg, cm1);
         want_lat = tb_legal(op) ? int'(cm1) + 2 : 1;
         do_req(a, b, op, sg, cm1, 1'b0);
         n_tests++;
         if (lat !== want_lat || out_data !== want || out_err !== !tb_legal(op)) begin
            n_fail++;
            $display("FAIL rand[%0d] op=%0d cm1=%0d: lat=%0d err=%b data=%h want %0d %b %h",
                     it, op, cm1, lat, out_err, out_data, want_lat, !tb_legal(op), want);
         end
         for (int k = 0; k < n_seen && k < 4; k++) begin
            n_tests++;
            if (seen[k].a !== a[k*64 +: 64] || seen[k].b !== b[k*64 +: 64] ||
                seen[k].oper !== op || seen[k].unsgn_or_sgn !== sg) begin
               n_fail++;
               $display("FAIL rand[%0d]_bus[%0d]: got %h want a=%h b=%h",
                        it, k, seen[k], a[k*64 +: 64], b[k*64 +: 64]);
            end
         end
         repeat ($urandom_range(0, 2)) tick();
         drain();
      end
   endtask

   initial begin
      test_reset();
      test_vec_add();
      test_scalar();
      test_illegal();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
